sdram_burst_sched: RTL and testbench
====================================

Name: sdram_burst_sched

Overview:
Parametrised multi-channel burst scheduler that sits between the per-channel FIFOs and the SDRAM command controller. It generalises the single-write/single-read arbitration of the current SDRAM interface to CH_NUM channels. Each channel is configured as write or read and owns an address window with automatic wrap-around. The block picks one eligible channel per burst in round-robin order and presents address and length to the controller through a req/ack/done handshake.

Parameters:
CH_NUM, 4, number of channels (2..8)
ADDR_W, 24, SDRAM linear address width
LEN_W, 10, burst length width
CNT_W, 10, FIFO fill-count width
FIFO_DEPTH, 512, depth of each channel FIFO (for read-space check)
CH_DIR, 4'b0011, per-channel direction bitmask; 1 = write (FIFO to SDRAM), 0 = read (SDRAM to FIFO)

Ports:
clk  in  1  scheduler clock (SDRAM controller clock)
rst_n  in  1  asynchronous active-low reset
ch_en  in  CH_NUM  channel enable
ch_addr_rst  in  CH_NUM  pulse: reload channel address pointer to its begin address
ch_fifo_cnt  in  CH_NUM*CNT_W  packed FIFO fill counts
ch_beg_addr  in  CH_NUM*ADDR_W  packed window begin addresses
ch_end_addr  in  CH_NUM*ADDR_W  packed window end addresses (inclusive)
ch_burst_len  in  CH_NUM*LEN_W  packed nominal burst lengths
burst_req  out  1  burst request to controller
burst_wr  out  1  1 = write burst, 0 = read burst
burst_ch  out  $clog2(CH_NUM)  granted channel index
burst_addr  out  ADDR_W  burst start address
burst_len  out  LEN_W  burst length actually issued
burst_ack  in  1  controller accepted request
burst_done  in  1  controller finished burst (1-cycle pulse)
ch_grant  out  CH_NUM  one-hot granted channel, held from REQ through BUSY

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer 0; each channel pointer = its ch_beg_addr, sampled on the first clk after reset release.
- Eligibility for channel i: ch_en[i] and len_i != 0 and beg_i <= end_i.
  - Write channel: additionally ch_fifo_cnt_i >= eff_len_i.
  - Read channel: additionally FIFO_DEPTH - ch_fifo_cnt_i >= eff_len_i.
- eff_len_i = min(len_i, end_i - ptr_i + 1). A burst is truncated at the window end and never crosses it.
- FSM IDLE: if any channel is eligible, pick the first eligible index searching from rr_ptr upward, modulo CH_NUM.
  - Register burst_ch, burst_addr = ptr, burst_len = eff_len, burst_wr = CH_DIR bit, and ch_grant.
  - Next cycle state is REQ with burst_req = 1. Selection latency is 1 cycle.
- FSM REQ: burst_req and all burst_* outputs stay stable until burst_ack = 1.
  - On that edge, burst_req drops and state goes to BUSY.
  - burst_done in REQ is ignored.
- FSM BUSY: wait for burst_done. On the done edge:
  - ptr = ptr + burst_len; if the result > end, ptr = beg (wrap).
  - rr_ptr = burst_ch + 1 mod CH_NUM.
  - ch_grant clears; state returns to IDLE.
  - Minimum gap between bursts is 1 IDLE cycle.
- ch_addr_rst[i] on a non-granted channel: ptr_i = beg_i next cycle.
- ch_addr_rst[i] on the granted channel: recorded as pending and applied at burst_done, overriding the advance.
- ch_addr_rst together with burst_done on the same channel: reload wins.
- ch_en drop on the granted channel: the burst in flight completes normally; the channel is excluded from the next arbitration.
- Window config changes while granted take effect only at the next arbitration.
- ptr_i outside [beg_i, end_i] at arbitration (config changed): ptr_i is reloaded to beg_i in IDLE and the channel is not eligible that cycle.
- Address arithmetic uses ADDR_W+1 bits to avoid overflow at the top of the address space.
- Asynchronous reset in REQ or BUSY: immediate return to IDLE, all outputs 0, pending reloads cleared.

Test Plan:
- 1 write channel: beg 0, end 19, len 10, fifo_cnt 10 → req with addr 0 / len 10, then addr 10 / len 10; after the second done, ptr wraps to 0.
- Truncation: beg 0, end 24, len 10 → bursts at addr 0, 10, 20; the burst at 20 has len 5; the next burst is at 0.
- Round robin with ch0..ch3 all eligible → grant order 0, 1, 2, 3, 0; after ch1 is disabled → order 2, 3, 0, 2.
- Read channel: FIFO_DEPTH 512, fifo_cnt 505, len 10 → not eligible. With cnt 502 → burst_wr = 0, len 10.
- Handshake: hold burst_ack low 7 cycles → burst_req and addr/len stable for all 7. burst_done injected in REQ → ignored.
- ch_addr_rst on the granted channel during BUSY → next burst from beg_addr. rst_n low in BUSY → all outputs 0 in the same cycle.

Source files
------------

// File: rtl/sdram_burst_sched.sv
// Round-robin burst scheduler: per-channel wrapping address windows, one burst per grant, 1-cycle select latency from IDLE.
// Request is held stable until burst_ack; the next arbitration happens one IDLE cycle after burst_done.
module sdram_burst_sched #(
    parameter int                CH_NUM     = 4,
    parameter int                ADDR_W     = 24,
    parameter int                LEN_W      = 10,
    parameter int                CNT_W      = 10,
    parameter int                FIFO_DEPTH = 512,
    parameter logic [CH_NUM-1:0] CH_DIR     = 4'b0011
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CH_NUM-1:0]           ch_en,
    input  logic [CH_NUM-1:0]           ch_addr_rst,
    input  logic [CH_NUM*CNT_W-1:0]     ch_fifo_cnt,
    input  logic [CH_NUM*ADDR_W-1:0]    ch_beg_addr,
    input  logic [CH_NUM*ADDR_W-1:0]    ch_end_addr,
    input  logic [CH_NUM*LEN_W-1:0]     ch_burst_len,
    output logic                        burst_req,
    output logic                        burst_wr,
    output logic [$clog2(CH_NUM)-1:0]   burst_ch,
    output logic [ADDR_W-1:0]           burst_addr,
    output logic [LEN_W-1:0]            burst_len,
    input  logic                        burst_ack,
    input  logic                        burst_done,
    output logic [CH_NUM-1:0]           ch_grant
);

    localparam int          CH_W    = $clog2(CH_NUM);
    localparam int          AW1     = ADDR_W + 1;
    localparam logic [31:0] DEPTH_U = 32'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;

    logic [ADDR_W-1:0] beg_a [CH_NUM];
    logic [ADDR_W-1:0] end_a [CH_NUM];
    logic [LEN_W-1:0]  len_a [CH_NUM];
    logic [CNT_W-1:0]  cnt_a [CH_NUM];

    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            beg_a[i] = ch_beg_addr[i*ADDR_W +: ADDR_W];
            end_a[i] = ch_end_addr[i*ADDR_W +: ADDR_W];
            len_a[i] = ch_burst_len[i*LEN_W +: LEN_W];
            cnt_a[i] = ch_fifo_cnt[i*CNT_W +: CNT_W];
        end
    end

    logic [1:0]        state_q, state_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              init_q, init_d;
    logic [ADDR_W-1:0] ptr_q [CH_NUM];
    logic [ADDR_W-1:0] ptr_d [CH_NUM];
    logic [CH_NUM-1:0] pend_q, pend_d;
    logic              burst_req_q, burst_req_d;
    logic              burst_wr_q, burst_wr_d;
    logic [CH_W-1:0]   burst_ch_q, burst_ch_d;
    logic [ADDR_W-1:0] burst_addr_q, burst_addr_d;
    logic [LEN_W-1:0]  burst_len_q, burst_len_d;
    logic [CH_NUM-1:0] grant_q, grant_d;
    logic [ADDR_W-1:0] win_beg_q, win_beg_d;
    logic [ADDR_W-1:0] win_end_q, win_end_d;

    // Window room and length are computed one bit wider so a window ending at the top address cannot overflow.
    logic [CH_NUM-1:0] in_win;
    logic [CH_NUM-1:0] space_ok;
    logic [CH_NUM-1:0] elig;
    logic [AW1-1:0]    room    [CH_NUM];
    logic [LEN_W-1:0]  eff_len [CH_NUM];

    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            in_win[i]  = (beg_a[i] <= end_a[i]) && (ptr_q[i] >= beg_a[i]) && (ptr_q[i] <= end_a[i]);
            room[i]    = AW1'(end_a[i]) - AW1'(ptr_q[i]) + AW1'(1);
            eff_len[i] = (AW1'(len_a[i]) < room[i]) ? len_a[i] : room[i][LEN_W-1:0];
            if (CH_DIR[i]) begin
                space_ok[i] = 32'(cnt_a[i]) >= 32'(eff_len[i]);
            end else begin
                space_ok[i] = (32'(cnt_a[i]) + 32'(eff_len[i])) <= DEPTH_U;
            end
            elig[i] = init_q && (state_q == ST_IDLE) && ch_en[i] && !ch_addr_rst[i]
                      && (len_a[i] != '0) && in_win[i] && space_ok[i];
        end
    end

    logic            found;
    logic [CH_W-1:0] pick;
    int              idx;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < CH_NUM; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= CH_NUM) begin
                idx = idx - CH_NUM;
            end
            if (!found && elig[CH_W'(idx)]) begin
                found = 1'b1;
                pick  = CH_W'(idx);
            end
        end
    end

    logic [AW1-1:0] adv;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        init_d       = 1'b1;
        pend_d       = pend_q;
        burst_req_d  = burst_req_q;
        burst_wr_d   = burst_wr_q;
        burst_ch_d   = burst_ch_q;
        burst_addr_d = burst_addr_q;
        burst_len_d  = burst_len_q;
        grant_d      = grant_q;
        win_beg_d    = win_beg_q;
        win_end_d    = win_end_q;
        adv          = AW1'(ptr_q[burst_ch_q]) + AW1'(burst_len_q);

        // A reload on the granted channel is deferred so the in-flight burst keeps a consistent pointer.
        for (int i = 0; i < CH_NUM; i++) begin
            ptr_d[i] = ptr_q[i];
            if (!init_q || ((state_q == ST_IDLE) && (ch_addr_rst[i] || !in_win[i]))) begin
                ptr_d[i] = beg_a[i];
            end else if ((state_q != ST_IDLE) && ch_addr_rst[i]) begin
                if (grant_q[i]) begin
                    pend_d[i] = 1'b1;
                end else begin
                    ptr_d[i] = beg_a[i];
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    burst_ch_d    = pick;
                    burst_addr_d  = ptr_q[pick];
                    burst_len_d   = eff_len[pick];
                    burst_wr_d    = CH_DIR[pick];
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    win_beg_d     = beg_a[pick];
                    win_end_d     = end_a[pick];
                    burst_req_d   = 1'b1;
                    state_d       = ST_REQ;
                end
            end
            ST_REQ: begin
                if (burst_ack) begin
                    burst_req_d = 1'b0;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (burst_done) begin
                    if (pend_q[burst_ch_q] || ch_addr_rst[burst_ch_q]) begin
                        ptr_d[burst_ch_q] = beg_a[burst_ch_q];
                    end else if (adv > {1'b0, win_end_q}) begin
                        ptr_d[burst_ch_q] = win_beg_q;
                    end else begin
                        ptr_d[burst_ch_q] = adv[ADDR_W-1:0];
                    end
                    pend_d   = '0;
                    grant_d  = '0;
                    rr_ptr_d = (burst_ch_q == CH_W'(CH_NUM - 1)) ? '0 : burst_ch_q + 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            init_q       <= 1'b0;
            pend_q       <= '0;
            burst_req_q  <= 1'b0;
            burst_wr_q   <= 1'b0;
            burst_ch_q   <= '0;
            burst_addr_q <= '0;
            burst_len_q  <= '0;
            grant_q      <= '0;
            win_beg_q    <= '0;
            win_end_q    <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            init_q       <= init_d;
            pend_q       <= pend_d;
            burst_req_q  <= burst_req_d;
            burst_wr_q   <= burst_wr_d;
            burst_ch_q   <= burst_ch_d;
            burst_addr_q <= burst_addr_d;
            burst_len_q  <= burst_len_d;
            grant_q      <= grant_d;
            win_beg_q    <= win_beg_d;
            win_end_q    <= win_end_d;
            for (int i = 0; i < CH_NUM; i++) begin
                ptr_q[i] <= ptr_d[i];
            end
        end
    end

    assign burst_req  = burst_req_q;
    assign burst_wr   = burst_wr_q;
    assign burst_ch   = burst_ch_q;
    assign burst_addr = burst_addr_q;
    assign burst_len  = burst_len_q;
    assign ch_grant   = grant_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
    a_req_in_req:   assert property (@(posedge clk) disable iff (!rst_n) burst_req_q == (state_q == ST_REQ));

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Randomized and directed bench for sdram_burst_sched against a queue-free arithmetic model of the channel windows.
module tb_sdram_burst_sched;

    localparam int          N     = 4;
    localparam int          AW    = 24;
    localparam int          LW    = 10;
    localparam int          CW    = 10;
    localparam int          DEPTH = 512;
    localparam logic [N-1:0] DIR  = 4'b0011;

    logic            clk         = 1'b0;
    logic            rst_n       = 1'b0;
    logic [N-1:0]    ch_en       = '0;
    logic [N-1:0]    ch_addr_rst = '0;
    logic [N*CW-1:0] ch_fifo_cnt = '0;
    logic [N*AW-1:0] ch_beg_addr = '0;
    logic [N*AW-1:0] ch_end_addr = '0;
    logic [N*LW-1:0] ch_burst_len = '0;
    logic            burst_ack   = 1'b0;
    logic            burst_done  = 1'b0;
    logic            burst_req;
    logic            burst_wr;
    logic [1:0]      burst_ch;
    logic [AW-1:0]   burst_addr;
    logic [LW-1:0]   burst_len;
    logic [N-1:0]    ch_grant;

    sdram_burst_sched #(
        .CH_NUM(N), .ADDR_W(AW), .LEN_W(LW), .CNT_W(CW), .FIFO_DEPTH(DEPTH), .CH_DIR(DIR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .ch_addr_rst(ch_addr_rst),
        .ch_fifo_cnt(ch_fifo_cnt), .ch_beg_addr(ch_beg_addr), .ch_end_addr(ch_end_addr),
        .ch_burst_len(ch_burst_len), .burst_req(burst_req), .burst_wr(burst_wr),
        .burst_ch(burst_ch), .burst_addr(burst_addr), .burst_len(burst_len),
        .burst_ack(burst_ack), .burst_done(burst_done), .ch_grant(ch_grant)
    );

    always #5 clk = ~clk;

    logic [N-1:0] dir_bits = DIR;
    bit           cfg_en  [N];
    int           cfg_beg [N];
    int           cfg_end [N];
    int           cfg_len [N];
    int           cfg_cnt [N];
    longint       mptr    [N];
    int           mrr;
    int           n_chk  = 0;
    int           n_pass = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < N; i++) begin
            ch_en[i]                   = cfg_en[i];
            ch_beg_addr[i*AW +: AW]    = AW'(cfg_beg[i]);
            ch_end_addr[i*AW +: AW]    = AW'(cfg_end[i]);
            ch_burst_len[i*LW +: LW]   = LW'(cfg_len[i]);
            ch_fifo_cnt[i*CW +: CW]    = CW'(cfg_cnt[i]);
        end
    endtask

    task automatic set_ch(input int i, input bit en, input int b, input int e, input int l, input int c);
        cfg_en[i] = en; cfg_beg[i] = b; cfg_end[i] = e; cfg_len[i] = l; cfg_cnt[i] = c;
    endtask

    // Applies config and reloads every pointer while the scheduler is idle.
    task automatic set_and_reload();
        apply_cfg();
        ch_addr_rst = '1;
        @(negedge clk);
        ch_addr_rst = '0;
        for (int i = 0; i < N; i++) mptr[i] = cfg_beg[i];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_req",   longint'(burst_req), 0);
        check_eq("rst_wr",    longint'(burst_wr), 0);
        check_eq("rst_ch",    longint'(burst_ch), 0);
        check_eq("rst_addr",  longint'(burst_addr), 0);
        check_eq("rst_len",   longint'(burst_len), 0);
        check_eq("rst_grant", longint'(ch_grant), 0);
        burst_ack = 1'b0; burst_done = 1'b0; ch_addr_rst = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) mptr[i] = cfg_beg[i];
        mrr = 0;
    endtask

    function automatic int model_pick(output int elen);
        int     i;
        longint e;
        elen = 0;
        for (int k = 0; k < N; k++) begin
            i = (mrr + k) % N;
            if (!cfg_en[i] || cfg_len[i] == 0 || cfg_beg[i] > cfg_end[i]) continue;
            if (mptr[i] < cfg_beg[i] || mptr[i] > cfg_end[i]) continue;
            e = cfg_end[i] - mptr[i] + 1;
            if (e > cfg_len[i]) e = cfg_len[i];
            if (dir_bits[i] ? (cfg_cnt[i] >= e) : (DEPTH - cfg_cnt[i] >= e)) begin
                elen = int'(e);
                return i;
            end
        end
        return -1;
    endfunction

    // reload_mode: 0 none, 1 ch_addr_rst during BUSY, 2 ch_addr_rst together with burst_done.
    task automatic do_burst(input int ack_dly, input bit done_in_req, input int reload_mode,
                            output int gch, output longint gaddr, output int glen);
        int     exp_ch, exp_len, w;
        longint exp_addr;
        exp_ch = model_pick(exp_len);
        gch = -1; gaddr = -1; glen = -1;
        w = 0;
        while (!burst_req && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (exp_ch < 0) begin
            check_eq("no_req", longint'(burst_req), 0);
            return;
        end
        check_eq("req_seen", longint'(burst_req), 1);
        if (!burst_req) return;
        exp_addr = mptr[exp_ch];
        gch = int'(burst_ch); gaddr = longint'(burst_addr); glen = int'(burst_len);
        check_eq("ch",    longint'(burst_ch), exp_ch);
        check_eq("addr",  longint'(burst_addr), exp_addr);
        check_eq("len",   longint'(burst_len), exp_len);
        check_eq("wr",    longint'(burst_wr), longint'(dir_bits[exp_ch]));
        check_eq("grant", longint'(ch_grant), longint'(1) << exp_ch);
        for (int c = 0; c < ack_dly; c++) begin
            burst_done = done_in_req && (c == 1);
            @(negedge clk);
            burst_done = 1'b0;
            check_eq("req_hold",  longint'(burst_req), 1);
            check_eq("addr_hold", longint'(burst_addr), exp_addr);
            check_eq("len_hold",  longint'(burst_len), exp_len);
        end
        burst_ack = 1'b1;
        @(negedge clk);
        burst_ack = 1'b0;
        check_eq("req_drop",   longint'(burst_req), 0);
        check_eq("grant_busy", longint'(ch_grant), longint'(1) << exp_ch);
        if (reload_mode == 1) begin
            ch_addr_rst[exp_ch] = 1'b1;
            @(negedge clk);
            ch_addr_rst = '0;
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        burst_done = 1'b1;
        if (reload_mode == 2) ch_addr_rst[exp_ch] = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
        ch_addr_rst = '0;
        check_eq("grant_clr", longint'(ch_grant), 0);
        if (reload_mode != 0) begin
            mptr[exp_ch] = cfg_beg[exp_ch];
        end else begin
            mptr[exp_ch] = mptr[exp_ch] + exp_len;
            if (mptr[exp_ch] > cfg_end[exp_ch]) mptr[exp_ch] = cfg_beg[exp_ch];
        end
        mrr = (exp_ch + 1) % N;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     gc, gl, rm;
        longint ga;
        int     rr_exp [9] = '{0, 1, 2, 3, 0, 2, 3, 0, 2};

        set_ch(0, 1, 0, 19, 10, 10);
        for (int i = 1; i < N; i++) set_ch(i, 0, 0, 100, 4, 0);
        apply_cfg();
        @(negedge clk);
        do_reset();

        // Single write channel with wrap.
        do_burst(1, 0, 0, gc, ga, gl); check_eq("t1_addr0", ga, 0);  check_eq("t1_len0", gl, 10);
        do_burst(0, 0, 0, gc, ga, gl); check_eq("t1_addr1", ga, 10); check_eq("t1_len1", gl, 10);
        do_burst(2, 0, 0, gc, ga, gl); check_eq("t1_wrap", ga, 0);

        // Truncation at the window end.
        set_ch(0, 1, 0, 24, 10, 10);
        set_and_reload();
        do_burst(0, 0, 0, gc, ga, gl); check_eq("t2_addr0", ga, 0);
        do_burst(0, 0, 0, gc, ga, gl); check_eq("t2_addr1", ga, 10);
        do_burst(0, 0, 0, gc, ga, gl); check_eq("t2_addr2", ga, 20); check_eq("t2_trunc", gl, 5);
        do_burst(0, 0, 0, gc, ga, gl); check_eq("t2_wrap", ga, 0);

        // Round robin, then channel 1 disabled.
        set_ch(0, 1, 0, 999, 8, 100);
        set_ch(1, 1, 0, 999, 8, 100);
        set_ch(2, 1, 0, 999, 8, 0);
        set_ch(3, 1, 0, 999, 8, 0);
        apply_cfg();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            do_burst(1, 0, 0, gc, ga, gl);
            check_eq("rr_order", gc, rr_exp[k]);
            if (k == 4) begin
                cfg_en[1] = 1'b0;
                apply_cfg();
            end
        end

        // Read channel space check.
        for (int i = 0; i < N; i++) cfg_en[i] = 1'b0;
        set_ch(2, 1, 0, 999, 10, 505);
        apply_cfg();
        do_burst(0, 0, 0, gc, ga, gl); check_eq("rd_full", gc, -1);
        cfg_cnt[2] = 502;
        apply_cfg();
        do_burst(0, 0, 0, gc, ga, gl); check_eq("rd_ch", gc, 2); check_eq("rd_len", gl, 10);

        // Long ack wait with a stray done during REQ.
        cfg_en[2] = 1'b0;
        set_ch(0, 1, 200, 999, 8, 100);
        set_and_reload();
        do_burst(7, 1, 0, gc, ga, gl); check_eq("hs_addr", ga, 200);
        do_burst(3, 1, 1, gc, ga, gl); check_eq("rl_addr", ga, 208);
        do_burst(0, 0, 2, gc, ga, gl); check_eq("rl_busy", ga, 200);
        do_burst(0, 0, 0, gc, ga, gl); check_eq("rl_done", ga, 200);

        // Window at the top of the address space.
        set_ch(0, 1, (1 << AW) - 16, (1 << AW) - 1, 10, 100);
        set_and_reload();
        do_burst(0, 0, 0, gc, ga, gl); check_eq("top_addr0", ga, (1 << AW) - 16);
        do_burst(0, 0, 0, gc, ga, gl); check_eq("top_len1", gl, 6);
        do_burst(0, 0, 0, gc, ga, gl); check_eq("top_wrap", ga, (1 << AW) - 16);

        // Reset asserted while BUSY with a pending reload.
        cfg_en[0] = 1'b0;
        set_ch(1, 1, 100, 999, 8, 100);
        set_and_reload();
        do_burst(0, 0, 0, gc, ga, gl); check_eq("pre_rst_addr", ga, 100);
        begin
            int w;
            w = 0;
            while (!burst_req && w < 20) begin @(negedge clk); w++; end
            check_eq("rb_req", longint'(burst_req), 1);
            burst_ack = 1'b1;
            @(negedge clk);
            burst_ack = 1'b0;
            ch_addr_rst[1] = 1'b1;
            @(negedge clk);
            ch_addr_rst = '0;
        end
        do_reset();
        do_burst(0, 0, 0, gc, ga, gl); check_eq("post_rst_addr", ga, 100);

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            if (it % 15 == 0) begin
                for (int i = 0; i < N; i++) begin
                    cfg_beg[i] = $urandom_range(0, 3000);
                    cfg_end[i] = cfg_beg[i] + $urandom_range(0, 40);
                end
            end
            for (int i = 0; i < N; i++) begin
                cfg_en[i]  = ($urandom_range(0, 3) != 0);
                cfg_len[i] = $urandom_range(0, 12);
                cfg_cnt[i] = dir_bits[i] ? $urandom_range(0, 14) : $urandom_range(496, 512);
            end
            if (it % 15 == 0) set_and_reload();
            else apply_cfg();
            rm = $urandom_range(0, 5);
            rm = (rm < 4) ? 0 : rm - 3;
            do_burst($urandom_range(0, 3), $urandom_range(0, 1), rm, gc, ga, gl);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
